div_4: RTL and testbench

- Sequential restoring divider, N-bit unsigned; the inverse of mult_4 (dividend/divisor in, quotient/remainder out).
- Same init/done handshake style as the shift-add multiplier, so the two blocks share control wiring and bench structure.
- Produces one quotient bit per clock.
- Sits beside mult_4 in the tt_um arithmetic tile.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_step.sv | 31 +++
 rtl/div_4.sv | 115 +++++++++++
 tb/tb_div_4.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and sizing helpers for the restoring divider.
//   state_t    : controller state encoding (IDLE, LOAD, ITER, DONE)
//   cnt_width  : width of the iteration down-counter for an N-bit divider
//   CNT_W      : counter width for the default 4-bit instance
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int N_DEFAULT = 4;

   // The counter is loaded with N, so it must be able to hold N itself.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

   localparam int CNT_W = cnt_width(N_DEFAULT);

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   r      in  N  partial remainder before this step
//   q_msb  in  1  dividend bit shifted into the remainder this step
//   d      in  N  divisor
//   r_sub  out N  shifted remainder minus divisor (valid when borrow=0)
//   q_bit  out 1  quotient bit produced by this step
//   borrow out 1  shifted remainder was smaller than the divisor
module div_step #(
   parameter int N = 4
) (
   input  logic [N-1:0] r,
   input  logic         q_msb,
   input  logic [N-1:0] d,
   output logic [N-1:0] r_sub,
   output logic         q_bit,
   output logic         borrow
);

   logic [N:0] t;

   assign t = {1'b0, r[N-2:0], q_msb} - {1'b0, d};

   // The remainder is always below D, so r[N-1] is only ever set ahead of the
   // final step, if at all. Should it be set, the shifted value is at least
   // 2^N and therefore exceeds any divisor, so no borrow can occur; the low N
   // bits of t are still the correct difference.
   assign borrow = t[N] & ~r[N-1];
   assign r_sub  = t[N-1:0];
   assign q_bit  = ~borrow;

endmodule

// File: rtl/div_4.sv
// div_4: sequential N-bit unsigned restoring divider, one quotient bit per clock.
//   clk         in  1  system clock, rising edge
//   rst         in  1  asynchronous active-high reset
//   init        in  1  start request, sampled only in IDLE
//   A           in  N  dividend, latched in LOAD
//   B           in  N  divisor, latched in LOAD
//   quot        out N  quotient (all ones on divide by zero)
//   rem         out N  remainder (dividend on divide by zero)
//   done        out 1  result valid, held while init stays high
//   div_by_zero out 1  latched divisor was zero
//
// state | meaning
// IDLE  | waiting for init, last results held, done=0
// LOAD  | latch operands, clear flags, short-circuit a zero divisor
// ITER  | N restoring steps, one quotient bit per cycle
// DONE  | done=1 until init falls
module div_4
   import div_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         init,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic [N-1:0] quot,
   output logic [N-1:0] rem,
   output logic         done,
   output logic         div_by_zero
);

   localparam int CW = cnt_width(N);

   state_t        state;
   logic [N-1:0]  r_reg;
   logic [N-1:0]  q_reg;
   logic [N-1:0]  d_reg;
   logic [CW-1:0] cnt;

   logic [N-1:0]  r_sub;
   logic          q_bit;
   logic          borrow;
   logic [N-1:0]  r_new;
   logic [N-1:0]  q_new;

   div_step #(.N(N)) u_step (
      .r      (r_reg),
      .q_msb  (q_reg[N-1]),
      .d      (d_reg),
      .r_sub  (r_sub),
      .q_bit  (q_bit),
      .borrow (borrow)
   );

   // On a borrow the subtraction is discarded and the plain shift is kept.
   assign r_new = borrow ? {r_reg[N-2:0], q_reg[N-1]} : r_sub;
   assign q_new = {q_reg[N-2:0], q_bit};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         r_reg       <= '0;
         q_reg       <= '0;
         d_reg       <= '0;
         cnt         <= '0;
         quot        <= '0;
         rem         <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (init) state <= LOAD;
            end
            LOAD: begin
               r_reg       <= '0;
               q_reg       <= A;
               d_reg       <= B;
               cnt         <= CW'(N);
               done        <= 1'b0;
               div_by_zero <= 1'b0;
               if (B == '0) begin
                  quot        <= '1;
                  rem         <= A;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                  state       <= DONE;
               end else begin
                  state <= ITER;
               end
            end
            ITER: begin
               r_reg <= r_new;
               q_reg <= q_new;
               cnt   <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  quot  <= q_new;
                  rem   <= r_new;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               if (!init) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_4.sv
// tb_div_4: self-checking bench for div_4 (N=4). Directed table, multi-cycle
// corner sequences, an exhaustive A/B sweep and randomized runs with operand
// toggling, all checked against plain integer division.
module tb_div_4;

   localparam int N = 4;

   logic         clk;
   logic         rst;
   logic         init;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic [N-1:0] quot;
   logic [N-1:0] rem;
   logic         done;
   logic         div_by_zero;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      int a;
      int b;
      int q;
      int r;
      int dz;
   } vec_t;

   vec_t vecs[10];

   div_4 #(.N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .init        (init),
      .A           (A),
      .B           (B),
      .quot        (quot),
      .rem         (rem),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void ref_div(input int a, input int b,
                                   output int q, output int r, output int dz);
      if (b == 0) begin
         q  = (1 << N) - 1;
         r  = a;
         dz = 1;
      end else begin
         q  = a / b;
         r  = a % b;
         dz = 0;
      end
   endfunction

   // Starts one division from IDLE (called at posedge+1), pulses init for one
   // cycle, counts edges until done, then checks results and the return to IDLE.
   task automatic run_op(input string name, input int a, input int b,
                         input int eq, input int er, input int edz, input bit toggle);
      int lat;
      int el;
      bit seen;
      el   = (b == 0) ? 2 : N + 2;
      A    = 4'(a);
      B    = 4'(b);
      init = 1'b1;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) init = 1'b0;
         if (toggle && lat >= 2) begin
            A = 4'($urandom);
            B = 4'($urandom);
         end
         if (done) seen = 1'b1;
      end
      check({name, " latency"}, lat, el);
      check({name, " quot"}, int'(quot), eq);
      check({name, " rem"}, int'(rem), er);
      check({name, " div_by_zero"}, int'(div_by_zero), edz);
      @(posedge clk);
      #1;
      check({name, " done_drop"}, int'(done), 0);
      check({name, " quot_held"}, int'(quot), eq);
   endtask

   initial begin
      int eq, er, edz;
      int rises;
      int first;
      bit prev;

      vecs[0] = '{a: 9,  b: 3,  q: 3,  r: 0, dz: 0};
      vecs[1] = '{a: 7,  b: 2,  q: 3,  r: 1, dz: 0};
      vecs[2] = '{a: 15, b: 1,  q: 15, r: 0, dz: 0};
      vecs[3] = '{a: 3,  b: 5,  q: 0,  r: 3, dz: 0};
      vecs[4] = '{a: 9,  b: 0,  q: 15, r: 9, dz: 1};
      vecs[5] = '{a: 8,  b: 4,  q: 2,  r: 0, dz: 0};
      vecs[6] = '{a: 0,  b: 7,  q: 0,  r: 0, dz: 0};
      vecs[7] = '{a: 15, b: 15, q: 1,  r: 0, dz: 0};
      vecs[8] = '{a: 15, b: 9,  q: 1,  r: 6, dz: 0};
      vecs[9] = '{a: 0,  b: 0,  q: 15, r: 0, dz: 1};

      rst  = 1'b1;
      init = 1'b0;
      A    = '0;
      B    = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset quot", int'(quot), 0);
      check("reset rem", int'(rem), 0);
      check("reset done", int'(done), 0);
      check("reset div_by_zero", int'(div_by_zero), 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle done", int'(done), 0);

      for (int i = 0; i < 10; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                vecs[i].q, vecs[i].r, vecs[i].dz, 1'b0);

      // Asynchronous reset in the third ITER cycle of 13/3.
      A    = 4'd13;
      B    = 4'd3;
      init = 1'b1;
      @(posedge clk); #1;
      init = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      check("midreset quot", int'(quot), 0);
      check("midreset rem", int'(rem), 0);
      check("midreset done", int'(done), 0);
      check("midreset div_by_zero", int'(div_by_zero), 0);
      #2 rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("postreset done", int'(done), 0);
      end
      run_op("after_reset", 13, 3, 4, 1, 0, 1'b0);

      // init held high for 20 cycles: exactly one run, no retrigger.
      A     = 4'd14;
      B     = 4'd4;
      init  = 1'b1;
      rises = 0;
      first = 0;
      prev  = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (i == 3) begin
            A = 4'd1;
            B = 4'd1;
         end
         if (done && !prev) begin
            rises++;
            if (first == 0) first = i;
         end
         prev = done;
      end
      check("hold rises", rises, 1);
      check("hold latency", first, 6);
      check("hold done", int'(done), 1);
      check("hold quot", int'(quot), 3);
      check("hold rem", int'(rem), 2);
      init = 1'b0;
      @(posedge clk); #1;
      check("hold release done", int'(done), 0);
      check("hold release quot", int'(quot), 3);
      check("hold release rem", int'(rem), 2);

      run_op("toggle", 11, 2, 5, 1, 0, 1'b1);

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++) begin
            ref_div(a, b, eq, er, edz);
            run_op($sformatf("sweep %0d/%0d", a, b), a, b, eq, er, edz, 1'b0);
         end

      for (int i = 0; i < 60; i++) begin
         int a;
         int b;
         a = int'($urandom_range(0, 15));
         b = int'($urandom_range(0, 15));
         ref_div(a, b, eq, er, edz);
         run_op($sformatf("rand %0d/%0d", a, b), a, b, eq, er, edz, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
